mole_spawner: RTL

- Upstream stage of the whack scorer. Generates the 3-bit mole position that the scorer compares against the A/W/X/D/S buttons.
- Pseudo-randomly pops a mole at one of five holes. Holds it for a score-dependent time, then hides it on a correct whack or a timeout.
- Consumes the scorer's cw, score and F15 outputs. Drives game_over to the display/FSM layer.

---
 rtl/whack_pkg.sv | 41 ++++
 rtl/mole_spawner_if.sv | 29 ++
 rtl/whack_tick_gen.sv | 36 +++
 rtl/mole_spawner.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/whack_pkg.sv
// Shared definitions for the whack game blocks (spawner and scorer).
// Holds the FSM state type, the hole position codes, the spawn hole table,
// the LFSR feedback mask and two small helpers used by the spawner.
package whack_pkg;

    typedef enum logic [1:0] {
        HIDDEN = 2'd0,
        UP     = 2'd1,
        DONE   = 2'd2
    } state_e;

    // Hole codes as seen by the scorer's button compare; 000 means no mole.
    localparam logic [2:0] POS_NONE = 3'b000;
    localparam logic [2:0] POS_A    = 3'b010;
    localparam logic [2:0] POS_W    = 3'b001;
    localparam logic [2:0] POS_D    = 3'b100;
    localparam logic [2:0] POS_X    = 3'b101;
    localparam logic [2:0] POS_S    = 3'b110;

    // Index 0..4 = A, W, D, X, S (element 0 is the rightmost).
    localparam logic [4:0][2:0] HOLE_TBL = {POS_S, POS_X, POS_D, POS_W, POS_A};

    // Right-shifting Galois mask for x^8 + x^6 + x^5 + x^4 + 1.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {1'b0, v[7:1]} ^ (v[0] ? LFSR_TAPS : 8'h00);
    endfunction

    // Pick the hole for lfsr value rnd, stepping to the next table entry
    // when the draw would repeat the previous hole.
    function automatic logic [2:0] pick_hole(input logic [7:0] rnd,
                                             input logic [2:0] last);
        logic [2:0] idx;
        idx = 3'(rnd % 8'd5);
        if (HOLE_TBL[idx] == last)
            idx = (idx == 3'd4) ? 3'd0 : idx + 3'd1;
        return HOLE_TBL[idx];
    endfunction

endpackage

// File: rtl/mole_spawner_if.sv
// Signal bundle between the mole spawner and its neighbours (keys, scorer,
// display layer).
//   key_esc, key_space : game restart / pause levels
//   cw, score, F15     : scorer feedback
//   mole_pos           : current hole code, 000 = none
//   hit_pulse, miss_pulse, misses, game_over : spawner status
// master = the spawner, slave = everything around it.
interface mole_spawner_if;
    logic       key_esc;
    logic       key_space;
    logic       cw;
    logic [3:0] score;
    logic       F15;
    logic [2:0] mole_pos;
    logic       hit_pulse;
    logic       miss_pulse;
    logic [1:0] misses;
    logic       game_over;

    modport master (
        input  key_esc, key_space, cw, score, F15,
        output mole_pos, hit_pulse, miss_pulse, misses, game_over
    );

    modport slave (
        output key_esc, key_space, cw, score, F15,
        input  mole_pos, hit_pulse, miss_pulse, misses, game_over
    );
endinterface

// File: rtl/whack_tick_gen.sv
// Game tick prescaler. Counts 0..TICK_DIV-1 while enabled and raises tick_o
// for the one clock in which the count wraps.
//   clk, rst_n : clock, async active-low reset
//   clr_i      : synchronous clear (overrides enable)
//   en_i       : count enable; low freezes the count and suppresses tick_o
//   tick_o     : one-clock game tick
module whack_tick_gen #(
    parameter int TICK_DIV = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);
    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && !clr_i && (cnt_q == W'(TICK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = tick_o ? '0 : cnt_q + W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
endmodule

// File: rtl/mole_spawner.sv
// Mole spawner: pops a mole at a pseudo-random hole, keeps it up for a
// score-dependent number of game ticks, and hides it on a correct whack or a
// timeout. Three timeouts or the scorer's F15 flag end the game.
//   clk, rst_n : clock, async active-low reset
//   bus        : mole_spawner_if.master (keys, scorer feedback, status out)
// All outputs are registered except game_over, which decodes the state.
module mole_spawner
    import whack_pkg::*;
#(
    parameter int         TICK_DIV   = 1000000,
    parameter int         GAP_TICKS  = 30,
    parameter int         HOLD_BASE  = 100,
    parameter int         HOLD_STEP  = 5,
    parameter int         HOLD_MIN   = 25,
    parameter int         MAX_MISSES = 3,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic           clk,
    input  logic           rst_n,
    mole_spawner_if.master bus
);
    // An all-zero Galois LFSR would lock up.
    localparam logic [7:0] SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

    state_e     state_q, state_d;
    logic [7:0] lfsr_q, lfsr_d;
    logic [2:0] pos_q, pos_d;
    logic [2:0] last_q, last_d;
    logic [7:0] gap_q, gap_d;
    logic [7:0] hcnt_q, hcnt_d;
    logic [7:0] hlen_q, hlen_d;
    logic [1:0] misses_q, misses_d;
    logic [2:0] mole_q, mole_d;
    logic       hit_q, hit_d;
    logic       miss_q, miss_d;

    logic       tick;
    logic       tick_en;
    logic [7:0] step_prod;
    logic [7:0] hold_raw;
    logic [7:0] hold_new;
    logic [2:0] spawn_pos;

    assign tick_en = !bus.key_space;

    whack_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (bus.key_esc),
        .en_i   (tick_en),
        .tick_o (tick)
    );

    // Up-time shrinks with score; saturate at zero before applying the floor.
    always_comb begin
        step_prod = 8'(HOLD_STEP) * {4'b0000, bus.score};
        hold_raw  = (step_prod >= 8'(HOLD_BASE)) ? 8'd0 : 8'(HOLD_BASE) - step_prod;
        hold_new  = (hold_raw < 8'(HOLD_MIN)) ? 8'(HOLD_MIN) : hold_raw;
    end

    assign spawn_pos = pick_hole(lfsr_q, last_q);

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        pos_d    = pos_q;
        last_d   = last_q;
        gap_d    = gap_q;
        hcnt_d   = hcnt_q;
        hlen_d   = hlen_q;
        misses_d = misses_q;
        mole_d   = POS_NONE;
        hit_d    = 1'b0;
        miss_d   = 1'b0;

        if (bus.key_esc) begin
            state_d  = HIDDEN;
            lfsr_d   = SEED;
            pos_d    = POS_NONE;
            last_d   = POS_NONE;
            gap_d    = '0;
            hcnt_d   = '0;
            hlen_d   = '0;
            misses_d = '0;
        end else if (!bus.key_space) begin
            // While paused everything holds and mole_d stays at POS_NONE.
            lfsr_d = lfsr_next(lfsr_q);
            unique case (state_q)
                HIDDEN: begin
                    if (bus.F15) begin
                        state_d = DONE;
                    end else if (tick) begin
                        if (gap_q + 8'd1 == 8'(GAP_TICKS)) begin
                            state_d = UP;
                            pos_d   = spawn_pos;
                            last_d  = spawn_pos;
                            hlen_d  = hold_new;
                            gap_d   = '0;
                            hcnt_d  = '0;
                            mole_d  = spawn_pos;
                        end else begin
                            gap_d = gap_q + 8'd1;
                        end
                    end
                end
                UP: begin
                    if (bus.F15) begin
                        state_d = DONE;
                    end else if (bus.cw) begin
                        // Hide at once so cw is seen for a single clock.
                        state_d = HIDDEN;
                        hit_d   = 1'b1;
                        gap_d   = '0;
                        hcnt_d  = '0;
                    end else if (tick && (hcnt_q + 8'd1 == hlen_q)) begin
                        miss_d  = 1'b1;
                        gap_d   = '0;
                        hcnt_d  = '0;
                        if (misses_q != 2'(MAX_MISSES))
                            misses_d = misses_q + 2'd1;
                        state_d = (misses_q + 2'd1 == 2'(MAX_MISSES)) ? DONE : HIDDEN;
                    end else begin
                        if (tick)
                            hcnt_d = hcnt_q + 8'd1;
                        mole_d = pos_q;
                    end
                end
                DONE: ;
                default: state_d = HIDDEN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= HIDDEN;
            lfsr_q   <= SEED;
            pos_q    <= POS_NONE;
            last_q   <= POS_NONE;
            gap_q    <= '0;
            hcnt_q   <= '0;
            hlen_q   <= '0;
            misses_q <= '0;
            mole_q   <= POS_NONE;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            pos_q    <= pos_d;
            last_q   <= last_d;
            gap_q    <= gap_d;
            hcnt_q   <= hcnt_d;
            hlen_q   <= hlen_d;
            misses_q <= misses_d;
            mole_q   <= mole_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
        end
    end

    assign bus.mole_pos   = mole_q;
    assign bus.hit_pulse  = hit_q;
    assign bus.miss_pulse = miss_q;
    assign bus.misses     = misses_q;
    assign bus.game_over  = (state_q == DONE);

endmodule
